// File: rtl/intel_temp_seq_if.sv
// Avalon-MM slave bus for the temperature sequencer register file.
// The master modport drives requests; the slave modport returns read data one cycle later.
interface intel_temp_seq_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata,
    output avs_readdatavalid
  );

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata,
    input  avs_readdatavalid
  );
endinterface

// File: rtl/intel_temp_seq.sv
// Temperature sensing diode sequencer: periodic TSD conversions guarded by a timeout,
// windowed averaging, fan control with hysteresis and a 4-word Avalon-MM register file.
module intel_temp_seq #(
  parameter logic [31:0] PeriodCycles  = 32'd1_000_000,
  parameter logic [7:0]  ClrCycles     = 8'd4,
  parameter logic [31:0] TimeoutCycles = 32'd2_000_000,
  parameter int unsigned AvgLog2       = 3,
  parameter logic [6:0]  FanOnTemp     = 7'd70,
  parameter logic [6:0]  FanOffTemp    = 7'd60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            tsdcalo,
  input  logic                  tsdcaldone,
  output logic                  tsd_clr,
  intel_temp_seq_if.slave       avs,
  output logic                  fan,
  output logic                  fan_n,
  output logic                  irq
);

  typedef enum logic [1:0] {StWait = 2'd0, StClr = 2'd1, StConv = 2'd2} state_e;

  localparam logic [1:0] RegStatus   = 2'd0;
  localparam logic [1:0] RegControl  = 2'd1;
  localparam logic [1:0] RegCounters = 2'd2;
  localparam logic [1:0] RegMaxTemp  = 2'd3;

  localparam logic [4:0] WinLast    = 5'((32'd1 << AvgLog2) - 32'd1);
  // TSD codes carry a +128 offset, so the 7-bit Celsius thresholds just gain a top bit.
  localparam logic [7:0] FanOnCode  = {1'b1, FanOnTemp};
  localparam logic [7:0] FanOffCode = {1'b1, FanOffTemp};

  state_e      state_q, state_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  logic [7:0]  last_q, last_d;
  logic [7:0]  avg_q, avg_d;
  logic        avg_valid_q, avg_valid_d;
  logic [7:0]  max_q, max_d;
  logic [11:0] acc_q, acc_d;
  logic [4:0]  win_cnt_q, win_cnt_d;
  logic [15:0] samples_q, samples_d;
  logic [15:0] timeouts_q, timeouts_d;
  logic        fan_state_q, fan_state_d;
  logic        alarm_q, alarm_d;
  logic        timeout_flag_q, timeout_flag_d;

  logic        enable_q, enable_d;
  logic        force_q, force_d;
  logic        sticky_q, sticky_d;
  logic        irq_en_q, irq_en_d;

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;

  logic        ctrl_wr, clr_wr, oneshot;
  logic        capture, timeout, period_done, clr_done;
  logic [11:0] sum, sum_shr;
  logic [7:0]  new_avg;
  logic [15:0] samples_base, timeouts_base;
  logic [7:0]  max_base;
  logic [1:0]  state_bits;
  logic        unused_bits;

  assign ctrl_wr     = avs.avs_write && (avs.avs_address == RegControl);
  assign clr_wr      = avs.avs_write && (avs.avs_address == RegMaxTemp);
  assign oneshot     = ctrl_wr && avs.avs_writedata[3];
  assign capture     = (state_q == StConv) && tsdcaldone;
  assign timeout     = (state_q == StConv) && !tsdcaldone &&
                       (tmo_cnt_q == TimeoutCycles - 32'd1);
  assign period_done = (period_cnt_q == PeriodCycles - 32'd1);
  assign clr_done    = (clr_cnt_q == ClrCycles - 8'd1);

  assign sum         = acc_q + {4'd0, tsdcalo};
  assign sum_shr     = sum >> AvgLog2;
  assign new_avg     = sum_shr[7:0];
  assign state_bits  = state_q;
  assign unused_bits = ^{avs.avs_writedata[31:5], sum_shr[11:8]};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClr;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StWait:  if (oneshot || (period_done && enable_q)) state_d = StClr;
      StClr:   if (clr_done) state_d = StConv;
      StConv:  if (capture || timeout) state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  // FSM: outputs
  always_comb begin
    tsd_clr = (state_q == StClr);
  end

  assign fan   = fan_state_q | force_q;
  assign fan_n = ~fan;
  assign irq   = alarm_q & irq_en_q;

  // Phase counters restart whenever their phase is not active.
  always_comb begin
    period_cnt_d = '0;
    clr_cnt_d    = '0;
    tmo_cnt_d    = '0;
    if (state_q == StWait) begin
      period_cnt_d = period_done ? period_cnt_q : period_cnt_q + 32'd1;
    end
    if (state_q == StClr) begin
      clr_cnt_d = clr_cnt_q + 8'd1;
    end
    if (state_q == StConv) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  // Capture, averaging, fan and alarm. A MAXTEMP clear is applied first so a
  // capture or timeout in the same cycle builds on the cleared values.
  always_comb begin
    last_d         = last_q;
    avg_d          = avg_q;
    avg_valid_d    = avg_valid_q;
    acc_d          = acc_q;
    win_cnt_d      = win_cnt_q;
    fan_state_d    = fan_state_q;
    samples_base   = clr_wr ? 16'd0 : samples_q;
    timeouts_base  = clr_wr ? 16'd0 : timeouts_q;
    max_base       = clr_wr ? 8'd0 : max_q;
    samples_d      = samples_base;
    timeouts_d     = timeouts_base;
    max_d          = max_base;
    alarm_d        = clr_wr ? 1'b0 : alarm_q;
    timeout_flag_d = clr_wr ? 1'b0 : timeout_flag_q;

    if (capture) begin
      last_d    = tsdcalo;
      samples_d = (samples_base == 16'hFFFF) ? samples_base : samples_base + 16'd1;
      max_d     = (tsdcalo > max_base) ? tsdcalo : max_base;
      if (win_cnt_q == WinLast) begin
        avg_d       = new_avg;
        avg_valid_d = 1'b1;
        acc_d       = '0;
        win_cnt_d   = '0;
        if (new_avg >= FanOnCode) begin
          fan_state_d = 1'b1;
          if (!fan_state_q) alarm_d = 1'b1;
        end else if ((new_avg <= FanOffCode) && !sticky_q) begin
          fan_state_d = 1'b0;
        end
      end else begin
        acc_d     = sum;
        win_cnt_d = win_cnt_q + 5'd1;
      end
    end

    if (timeout) begin
      timeouts_d     = (timeouts_base == 16'hFFFF) ? timeouts_base : timeouts_base + 16'd1;
      timeout_flag_d = 1'b1;
      alarm_d        = 1'b1;
    end
  end

  always_comb begin
    enable_d = enable_q;
    force_d  = force_q;
    sticky_d = sticky_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      enable_d = avs.avs_writedata[0];
      force_d  = avs.avs_writedata[1];
      sticky_d = avs.avs_writedata[2];
      irq_en_d = avs.avs_writedata[4];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (avs.avs_read) begin
      case (avs.avs_address)
        RegStatus:   rdata_d = {10'd0, state_bits, timeout_flag_q, alarm_q, fan, avg_valid_q,
                                avg_q, last_q};
        RegControl:  rdata_d = {27'd0, irq_en_q, 1'b0, sticky_q, force_q, enable_q};
        RegCounters: rdata_d = {timeouts_q, samples_q};
        RegMaxTemp:  rdata_d = {24'd0, max_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt_q   <= '0;
      clr_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      last_q         <= '0;
      avg_q          <= '0;
      avg_valid_q    <= 1'b0;
      max_q          <= '0;
      acc_q          <= '0;
      win_cnt_q      <= '0;
      samples_q      <= '0;
      timeouts_q     <= '0;
      fan_state_q    <= 1'b0;
      alarm_q        <= 1'b0;
      timeout_flag_q <= 1'b0;
      enable_q       <= 1'b1;
      force_q        <= 1'b0;
      sticky_q       <= 1'b1;
      irq_en_q       <= 1'b0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
    end else begin
      period_cnt_q   <= period_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      last_q         <= last_d;
      avg_q          <= avg_d;
      avg_valid_q    <= avg_valid_d;
      max_q          <= max_d;
      acc_q          <= acc_d;
      win_cnt_q      <= win_cnt_d;
      samples_q      <= samples_d;
      timeouts_q     <= timeouts_d;
      fan_state_q    <= fan_state_d;
      alarm_q        <= alarm_d;
      timeout_flag_q <= timeout_flag_d;
      enable_q       <= enable_d;
      force_q        <= force_d;
      sticky_q       <= sticky_d;
      irq_en_q       <= irq_en_d;
      rdata_q        <= rdata_d;
      rvalid_q       <= avs.avs_read;
    end
  end

  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_intel_temp_seq.sv
// Scoreboarded bench for intel_temp_seq: a TSD model feeds randomized codes, a
// window-based reference model predicts register contents, a monitor checks reads.
module tb_intel_temp_seq;
  localparam int Period = 100;
  localparam int Clr    = 4;
  localparam int Tmo    = 1000;
  localparam int Log2   = 2;
  localparam int Win    = 1 << Log2;
  localparam int OnCode = 70 + 128;
  localparam int OffCode = 60 + 128;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tsdcalo = 8'd0;
  logic       tsdcaldone = 1'b0;
  logic       tsd_clr, fan, fan_n, irq;

  intel_temp_seq_if avs ();

  intel_temp_seq #(
    .PeriodCycles (32'd100),
    .ClrCycles    (8'd4),
    .TimeoutCycles(32'd1000),
    .AvgLog2      (2),
    .FanOnTemp    (7'd70),
    .FanOffTemp   (7'd60)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tsdcalo   (tsdcalo),
    .tsdcaldone(tsdcaldone),
    .tsd_clr   (tsd_clr),
    .avs       (avs),
    .fan       (fan),
    .fan_n     (fan_n),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  // Reference model state
  logic [7:0] m_last, m_avg, m_max;
  bit         m_avg_valid, m_fan_st, m_alarm, m_tf, m_en, m_force, m_sticky, m_irq_en;
  int         m_samples, m_timeouts;
  int         m_win[$];
  int         last_rise = 0;
  int         next_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    m_max = 0; m_alarm = 0; m_tf = 0; m_samples = 0; m_timeouts = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_last = 0; m_avg = 0; m_avg_valid = 0; m_fan_st = 0;
    m_en = 1; m_force = 0; m_sticky = 1; m_irq_en = 0;
    m_win.delete();
  endfunction

  function automatic void model_sample(input logic [7:0] code, input bit clear);
    int sum;
    if (clear) model_clear();
    m_last = code;
    if (m_samples < 65535) m_samples++;
    if (code > m_max) m_max = code;
    m_win.push_back(int'(code));
    if (m_win.size() == Win) begin
      sum = 0;
      foreach (m_win[i]) sum += m_win[i];
      m_avg = 8'(sum / Win);
      m_avg_valid = 1;
      m_win.delete();
      if (int'(m_avg) >= OnCode) begin
        if (!m_fan_st) m_alarm = 1;
        m_fan_st = 1;
      end else if (int'(m_avg) <= OffCode && !m_sticky) begin
        m_fan_st = 0;
      end
    end
  endfunction

  function automatic void model_timeout();
    if (m_timeouts < 65535) m_timeouts++;
    m_tf = 1;
    m_alarm = 1;
  endfunction

  function automatic logic [31:0] exp_status(input logic [1:0] st);
    return {10'd0, st, m_tf, m_alarm, (m_fan_st | m_force), m_avg_valid, m_avg, m_last};
  endfunction

  function automatic logic [31:0] exp_ctrl();
    return {27'd0, m_irq_en, 1'b0, m_sticky, m_force, m_en};
  endfunction

  // Monitor: every read-data beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && avs.avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_readdatavalid: got %h expected none", avs.avs_readdata);
      end else begin
        check(name_q.pop_front(), avs.avs_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic rd_issue(input logic [1:0] a, input logic [31:0] e, input string n);
    avs.avs_address = a;
    avs.avs_read = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    avs.avs_read = 1'b0;
  endtask

  task automatic read_all(input logic [1:0] st);
    rd_issue(2'd0, exp_status(st), "status");
    rd_issue(2'd1, exp_ctrl(), "control");
    rd_issue(2'd2, {16'(m_timeouts), 16'(m_samples)}, "counters");
    rd_issue(2'd3, {24'd0, m_max}, "maxtemp");
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs.avs_address = a;
    avs.avs_writedata = d;
    avs.avs_write = 1'b1;
    @(negedge clk);
    avs.avs_write = 1'b0;
    if (a == 2'd1) begin
      m_en = d[0]; m_force = d[1]; m_sticky = d[2]; m_irq_en = d[4];
    end else if (a == 2'd3) begin
      model_clear();
    end
  endtask

  task automatic pins();
    bit ef, ei;
    ef = m_fan_st | m_force;
    ei = m_alarm & m_irq_en;
    check("fan", {31'd0, fan}, {31'd0, ef});
    check("fan_n", {31'd0, fan_n}, {31'd0, !ef});
    check("irq", {31'd0, irq}, {31'd0, ei});
  endtask

  // d = CONV cycle on which done is presented; d == 0 means the TSD never answers.
  task automatic run_conv(input logic [7:0] code, input int d, input int exp_gap,
                          input bit rd_clr, input bit rd_conv, input bit collide);
    int n, h, k;
    n = 0;
    while (tsd_clr !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("clr_rise_seen", {31'd0, tsd_clr}, 32'd1);
    if (exp_gap > 0) check("clr_start_gap", cyc - last_rise, exp_gap);
    last_rise = cyc;
    h = 0;
    while (tsd_clr === 1'b1 && h < 300) begin
      if (h == 0 && rd_clr) begin
        avs.avs_address = 2'd0;
        avs.avs_read = 1'b1;
        exp_q.push_back(exp_status(2'd1));
        name_q.push_back("status_in_clr");
      end
      @(negedge clk);
      avs.avs_read = 1'b0;
      h++;
    end
    check("clr_pulse_len", h, Clr);
    if (d == 0) begin
      repeat (Tmo - 1) @(negedge clk);
      rd_issue(2'd0, exp_status(2'd2), "status_last_conv_cycle");
      model_timeout();
      rd_issue(2'd0, exp_status(2'd0), "status_after_timeout");
      return;
    end
    k = 1;
    if (rd_conv) begin
      rd_issue(2'd0, exp_status(2'd2), "status_in_conv");
      k = 2;
    end
    while (k < d) begin
      @(negedge clk);
      k++;
    end
    tsdcalo = code;
    tsdcaldone = 1'b1;
    if (collide) begin
      avs.avs_address = 2'd3;
      avs.avs_writedata = 32'hFFFF_FFFF;
      avs.avs_write = 1'b1;
    end
    @(negedge clk);
    avs.avs_write = 1'b0;
    model_sample(code, collide);
    // Done stays high into WAIT with a different code; it must be ignored there.
    tsdcalo = ~code;
    repeat (2) @(negedge clk);
    tsdcaldone = 1'b0;
  endtask

  task automatic conv_std(input logic [7:0] code, input int d);
    run_conv(code, d, next_gap, 1'b0, 1'b0, 1'b0);
    next_gap = Clr + d + Period;
    read_all(2'd0);
    pins();
  endtask

  task automatic expect_idle(input int n);
    int r;
    r = 0;
    repeat (n) begin
      @(negedge clk);
      if (tsd_clr) r++;
    end
    check("idle_no_clr", r, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish by time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] c;
    bit s, ie;
    avs.avs_address = 2'd0;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
    avs.avs_writedata = 32'd0;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_tsd_clr", {31'd0, tsd_clr}, 32'd1);
    check("reset_rdv", {31'd0, avs.avs_readdatavalid}, 32'd0);
    pins();
    reset = 1'b0;

    // Periodic conversion, state visible as CLR then CONV
    run_conv(8'd153, 50, 0, 1'b1, 1'b1, 1'b0);
    next_gap = Clr + 50 + Period;
    read_all(2'd0);
    for (int i = 0; i < 3; i++) conv_std(8'($urandom_range(150, 185)), $urandom_range(2, 60));

    // Averaging and hysteresis
    wr(2'd1, 32'h15);
    conv_std(8'd196, 10);
    conv_std(8'd198, 20);
    conv_std(8'd200, 30);
    conv_std(8'd202, 40);
    wr(2'd1, 32'h11);
    for (int i = 0; i < 4; i++) conv_std(8'd186, $urandom_range(1, 60));
    for (int i = 0; i < 4; i++) conv_std(8'd190, $urandom_range(1, 60));
    wr(2'd3, 32'd0);
    read_all(2'd0);

    // Timeout, then a colliding MAXTEMP clear on the next capture
    run_conv(8'd0, 0, next_gap, 1'b0, 1'b0, 1'b0);
    read_all(2'd0);
    pins();
    run_conv(8'd170, 25, Clr + Tmo + Period, 1'b0, 1'b0, 1'b1);
    next_gap = Clr + 25 + Period;
    read_all(2'd0);
    pins();

    // Randomized conversions and control settings
    for (int i = 0; i < 8; i++) begin
      s  = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      wr(2'd1, {27'd0, ie, 1'b0, s, 1'b0, 1'b1});
      conv_std(8'($urandom_range(170, 215)), $urandom_range(1, 80));
    end

    // One-shot while disabled
    wr(2'd1, 32'h4);
    expect_idle(300);
    wr(2'd1, 32'h8);
    check("oneshot_clr_next_cycle", {31'd0, tsd_clr}, 32'd1);
    run_conv(8'($urandom_range(150, 215)), 30, 0, 1'b0, 1'b0, 1'b0);
    read_all(2'd0);
    expect_idle(300);

    // Force, then reset in the middle of a conversion
    wr(2'd1, 32'h2);
    pins();
    wr(2'd1, 32'hA);
    check("oneshot2_clr", {31'd0, tsd_clr}, 32'd1);
    n = 0;
    while (tsd_clr === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("midconv_reset_tsd_clr", {31'd0, tsd_clr}, 32'd1);
    check("midconv_reset_rdv", {31'd0, avs.avs_readdatavalid}, 32'd0);
    pins();
    reset = 1'b0;
    next_gap = 0;
    for (int i = 0; i < 4; i++) begin
      c = 8'($urandom_range(150, 230));
      conv_std(c, $urandom_range(1, 60));
    end

    repeat (3) @(negedge clk);
    check("read_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
